// File: rtl/alu_cmd_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_unit
// Brief    : Handshaked single-command ALU with a shift-add iterative multiply.
// Revision : 1.0 - initial release
// ============================================================================
module alu_cmd_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       in_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero
);

    localparam int         c_SH_W    = $clog2(WIDTH);
    localparam logic [3:0] c_OP_ADD  = 4'd0;
    localparam logic [3:0] c_OP_SUB  = 4'd1;
    localparam logic [3:0] c_OP_AND  = 4'd2;
    localparam logic [3:0] c_OP_OR   = 4'd3;
    localparam logic [3:0] c_OP_XOR  = 4'd4;
    localparam logic [3:0] c_OP_NOR  = 4'd5;
    localparam logic [3:0] c_OP_SLL  = 4'd6;
    localparam logic [3:0] c_OP_SRL  = 4'd7;
    localparam logic [3:0] c_OP_SRA  = 4'd8;
    localparam logic [3:0] c_OP_SLT  = 4'd9;
    localparam logic [3:0] c_OP_SLTU = 4'd10;
    localparam logic [3:0] c_OP_MUL  = 4'd11;
    localparam logic [3:0] c_OP_PSA  = 4'd12;
    localparam logic [3:0] c_OP_PSB  = 4'd13;
    localparam logic [3:0] c_OP_NEG  = 4'd14;
    localparam logic [3:0] c_OP_NOT  = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_mul_a;
    logic [WIDTH-1:0]   r_mul_b;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_y;
    logic [c_SH_W-1:0]  r_cnt;
    logic [WIDTH-1:0]   w_alu_y;
    logic [WIDTH-1:0]   w_acc_nxt;
    logic [c_SH_W-1:0]  w_sh;
    logic               w_accept;
    logic               w_last;

    assign in_ready  = (r_state == ST_IDLE) & ~rst;
    assign w_accept  = in_valid & in_ready;
    assign out_valid = (r_state == ST_DONE);
    assign out_y     = r_y;
    assign out_zero  = (r_y == '0);

    assign w_sh      = in_b[c_SH_W-1:0];
    assign w_acc_nxt = r_acc + (r_mul_b[0] ? r_mul_a : '0);
    assign w_last    = (r_cnt == {c_SH_W{1'b1}});

    // Single-cycle ops; MUL is produced by the iterative path instead.
    always_comb begin
        w_alu_y = '0;
        case (in_sel)
            c_OP_ADD:  w_alu_y = in_a + in_b;
            c_OP_SUB:  w_alu_y = in_a - in_b;
            c_OP_AND:  w_alu_y = in_a & in_b;
            c_OP_OR:   w_alu_y = in_a | in_b;
            c_OP_XOR:  w_alu_y = in_a ^ in_b;
            c_OP_NOR:  w_alu_y = ~(in_a | in_b);
            c_OP_SLL:  w_alu_y = in_a << w_sh;
            c_OP_SRL:  w_alu_y = in_a >> w_sh;
            c_OP_SRA:  w_alu_y = $unsigned($signed(in_a) >>> w_sh);
            c_OP_SLT:  w_alu_y = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            c_OP_SLTU: w_alu_y = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
            c_OP_PSA:  w_alu_y = in_a;
            c_OP_PSB:  w_alu_y = in_b;
            c_OP_NEG:  w_alu_y = -in_a;
            c_OP_NOT:  w_alu_y = ~in_a;
            default:   w_alu_y = '0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = (in_sel == c_OP_MUL) ? ST_MUL : ST_DONE;
            ST_MUL:  if (w_last)   w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_mul_a <= '0;
            r_mul_b <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_y     <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_mul_a <= in_a;
                        r_mul_b <= in_b;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        if (in_sel != c_OP_MUL) r_y <= w_alu_y;
                    end
                end
                // Fixed WIDTH iterations, no early exit on a zero multiplier.
                ST_MUL: begin
                    r_acc   <= w_acc_nxt;
                    r_mul_a <= r_mul_a << 1;
                    r_mul_b <= r_mul_b >> 1;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) r_y <= w_acc_nxt;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_cmd_unit
// Brief    : Self-checking bench for alu_cmd_unit against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_unit;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [3:0]       in_sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic             out_zero;

    int n_checks = 0;
    int n_fail   = 0;

    alu_cmd_unit #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] sel);
        int unsigned sh;
        logic [31:0] r;
        sh = b % 32;
        case (sel)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = ~(a | b);
            4'd6:  r = a << sh;
            4'd7:  r = a >> sh;
            4'd8:  r = $signed(a) >>> sh;
            4'd9:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd10: r = (a < b) ? 32'd1 : 32'd0;
            4'd11: r = a * b;
            4'd12: r = a;
            4'd13: r = b;
            4'd14: r = 32'd0 - a;
            default: r = ~a;
        endcase
        return r;
    endfunction

    // Issue one command, wait for its result with out_ready high, complete the handshake.
    task automatic do_cmd(input logic [31:0] a, input logic [31:0] b, input logic [3:0] sel,
                          input bit jitter, output logic [31:0] y, output logic z,
                          output int lat, output int rdy_err);
        int guard;
        rdy_err = 0;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        in_a = a; in_b = b; in_sel = sel; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            if (in_ready) rdy_err++;
            if (jitter) begin
                in_a     = $urandom;
                in_b     = $urandom;
                in_valid = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        y = out_y;
        z = out_zero;
        if (out_valid) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_a = 32'd1; in_b = 32'd2; in_sel = 4'd0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (out_y !== 32'd0) begin n_fail++; $display("FAIL reset_out_y: got %h want 0", out_y); end
        n_checks++; if (out_zero !== 1'b1) begin n_fail++; $display("FAIL reset_out_zero: got %b want 1", out_zero); end
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_directed();
        logic [31:0] a, b, e, y;
        logic [3:0]  sel;
        logic        z;
        int          lat, rerr;
        for (int k = 0; k < 11; k++) begin
            case (k)
                0:  begin a = 32'd5;        b = 32'd7;  sel = 4'd0;  e = 32'd12;       end
                1:  begin a = 32'd3;        b = 32'd5;  sel = 4'd1;  e = 32'hFFFFFFFE; end
                2:  begin a = 32'd9;        b = 32'd9;  sel = 4'd1;  e = 32'd0;        end
                3:  begin a = 32'h7FFFFFFF; b = 32'd1;  sel = 4'd0;  e = 32'h80000000; end
                4:  begin a = 32'h80000000; b = 32'd4;  sel = 4'd8;  e = 32'hF8000000; end
                5:  begin a = 32'h80000000; b = 32'd4;  sel = 4'd7;  e = 32'h08000000; end
                6:  begin a = 32'd1;        b = 32'h21; sel = 4'd6;  e = 32'd2;        end
                7:  begin a = 32'hFFFFFFFF; b = 32'd1;  sel = 4'd9;  e = 32'd1;        end
                8:  begin a = 32'hFFFFFFFF; b = 32'd1;  sel = 4'd10; e = 32'd0;        end
                9:  begin a = 32'h80000000; b = 32'd0;  sel = 4'd14; e = 32'h80000000; end
                default: begin a = 32'd1;   b = 32'h20; sel = 4'd6;  e = 32'd1;        end
            endcase
            do_cmd(a, b, sel, 1'b0, y, z, lat, rerr);
            n_checks++; if (y !== e) begin n_fail++; $display("FAIL dir%0d_y: got %h want %h", k, y, e); end
            n_checks++; if (z !== (e == 32'd0)) begin n_fail++; $display("FAIL dir%0d_zero: got %b want %b", k, z, (e == 32'd0)); end
            n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL dir%0d_latency: got %0d want 1", k, lat); end
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dir%0d_valid_drop: got %b want 0", k, out_valid); end
        end
    endtask

    task automatic test_mul();
        logic [31:0] y;
        logic        z;
        int          lat, rerr;
        do_cmd(32'hFFFFFFFF, 32'd3, 4'd11, 1'b1, y, z, lat, rerr);
        n_checks++; if (y !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL mul_y: got %h want fffffffd", y); end
        n_checks++; if (lat !== WIDTH + 1) begin n_fail++; $display("FAIL mul_latency: got %0d want %0d", lat, WIDTH + 1); end
        n_checks++; if (rerr !== 0) begin n_fail++; $display("FAIL mul_in_ready: got %0d cycles high want 0", rerr); end
        n_checks++; if (out_y !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL mul_y_hold: got %h want fffffffd", out_y); end
    endtask

    task automatic test_backpressure();
        int held_err;
        held_err = 0;
        in_a = 32'd20; in_b = 32'd22; in_sel = 4'd0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_a = 32'd1; in_b = 32'd1; in_sel = 4'd1;
        for (int i = 0; i < 5; i++) begin
            if (!out_valid || out_y !== 32'd42 || out_zero !== 1'b0 || in_ready) held_err++;
            @(posedge clk); #1;
        end
        n_checks++; if (held_err !== 0) begin n_fail++; $display("FAIL bp_hold: got %0d bad cycles want 0", held_err); end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_valid_drop: got %b want 0", out_valid); end
        n_checks++; if (out_y !== 32'd42) begin n_fail++; $display("FAIL bp_y_after: got %h want 0000002a", out_y); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after: got %b want 1", in_ready); end
    endtask

    task automatic test_reset_mid_mul();
        logic [31:0] y;
        logic        z;
        int          lat, rerr;
        in_a = 32'd7; in_b = 32'd9; in_sel = 4'd11; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmul_valid: got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rstmul_ready_in_rst: got %b want 0", in_ready); end
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmul_ready: got %b want 1", in_ready); end
        n_checks++; if (out_y !== 32'd0) begin n_fail++; $display("FAIL rstmul_y: got %h want 0", out_y); end
        do_cmd(32'd100, 32'd23, 4'd0, 1'b0, y, z, lat, rerr);
        n_checks++; if (y !== 32'd123) begin n_fail++; $display("FAIL rstmul_next_add: got %h want 0000007b", y); end
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL rstmul_next_latency: got %0d want 1", lat); end
    endtask

    task automatic test_random_sweep();
        logic [31:0] a, b, e, y;
        logic        z;
        int          lat, rerr, exp_lat;
        for (int i = 0; i < 50; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 5 == 0) b = $urandom_range(0, 40);
            if (i % 7 == 0) a = b;
            for (int s = 0; s < 16; s++) begin
                e = model(a, b, 4'(s));
                exp_lat = (s == 11) ? WIDTH + 1 : 1;
                do_cmd(a, b, 4'(s), 1'b0, y, z, lat, rerr);
                n_checks++; if (y !== e) begin n_fail++; $display("FAIL rnd_y sel=%0d a=%h b=%h: got %h want %h", s, a, b, y, e); end
                n_checks++; if (z !== (e == 32'd0)) begin n_fail++; $display("FAIL rnd_zero sel=%0d: got %b want %b", s, z, (e == 32'd0)); end
                n_checks++; if (lat !== exp_lat) begin n_fail++; $display("FAIL rnd_latency sel=%0d: got %0d want %0d", s, lat, exp_lat); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mul();
        test_backpressure();
        test_reset_mid_mul();
        test_random_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
